// File: rtl/io_output_disp.sv
// Memory-mapped seven-segment output port bank with a shared double-dabble converter.
// Optional build macro IO_OUT_LEADZ_BLANK_EN blanks leading zero digits in decimal mode.
module io_output_disp #(
    parameter int          NPORTS    = 3,
    parameter int          DATA_W    = 8,
    parameter int          DIGITS    = 2,
    parameter logic [5:0]  BASE_WORD = 6'h20
) (
    input  logic                         io_clk,
    input  logic                         clrn,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  datain,
    input  logic                         write_io_enable,
    output logic [NPORTS*DIGITS*7-1:0]   seg_out,
    output logic                         busy,
    output logic [31:0]                  rd_data
);

    localparam int ACC_W = DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int SEL_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   value   [NPORTS];
    logic [ACC_W-1:0]    digits  [NPORTS];
    logic [NPORTS-1:0]   pending;
    logic [NPORTS-1:0]   mode;
    logic [SEL_W-1:0]    sel;
    logic                dirty;
    logic [DATA_W-1:0]   shreg;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;

    logic [NPORTS-1:0]   wr_port;
    logic                wr_ctrl;
    logic [NPORTS-1:0]   mode_new;
    logic [DATA_W-1:0]   value_new [NPORTS];
    logic [NPORTS-1:0]   set_pend;
    logic [NPORTS-1:0]   reload;
    logic [NPORTS-1:0]   pend_nx;
    logic [SEL_W-1:0]    first;
    logic [ACC_W-1:0]    adj;
    logic [ACC_W-1:0]    acc_nx;
    logic [DATA_W-1:0]   shreg_nx;

    logic unused_bits;
    assign unused_bits = ^{addr[31:8], addr[1:0], datain};

    function automatic logic [ACC_W-1:0] hex_nib(input logic [DATA_W-1:0] v);
        logic [ACC_W+DATA_W-1:0] t;
        t = {{ACC_W{1'b0}}, v};
        return t[ACC_W-1:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'ha: return 7'b0001000;
            4'hb: return 7'b0000011;
            4'hc: return 7'b1000110;
            4'hd: return 7'b0100001;
            4'he: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Port writes land first; the mode decision then looks at the updated value.
    always_comb begin
        wr_ctrl  = write_io_enable && (addr[7:2] == BASE_WORD + 6'(NPORTS));
        mode_new = wr_ctrl ? datain[NPORTS-1:0] : mode;
        for (int i = 0; i < NPORTS; i++) begin
            wr_port[i]   = write_io_enable && (addr[7:2] == BASE_WORD + 6'(i));
            value_new[i] = wr_port[i] ? datain[DATA_W-1:0] : value[i];
            set_pend[i]  = !mode_new[i] && (wr_port[i] || (wr_ctrl && mode[i]));
            reload[i]    = mode_new[i] && (wr_port[i] || wr_ctrl);
        end
    end

    // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        first = '0;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (pending[i]) first = SEL_W'(i);
    end

    // A port rewritten while it is converting stays pending so it reconverts after the stale commit.
    always_comb begin
        pend_nx = (pending | set_pend) & ~mode_new;
        if (state == COMMIT && !(dirty || set_pend[sel]))
            pend_nx[sel] = 1'b0;
    end

    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++)
            adj[d*4 +: 4] = (acc[d*4 +: 4] >= 4'd5) ? acc[d*4 +: 4] + 4'd3 : acc[d*4 +: 4];
        {acc_nx, shreg_nx} = {adj, shreg} << 1;
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            pending <= '0;
            mode    <= '0;
            sel     <= '0;
            dirty   <= 1'b0;
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            // NOTE: the port and digit arrays are reset too, because the display must read "0" straight out of reset.
            for (int i = 0; i < NPORTS; i++) begin
                value[i]  <= '0;
                digits[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            mode    <= mode_new;
            pending <= pend_nx;
            for (int i = 0; i < NPORTS; i++) begin
                value[i] <= value_new[i];
                if (reload[i]) digits[i] <= hex_nib(value_new[i]);
            end
            case (state)
                IDLE: begin
                    if (|pending) begin
                        sel   <= first;
                        shreg <= value[first];
                        acc   <= '0;
                        cnt   <= CNT_W'(DATA_W);
                        dirty <= set_pend[first];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= acc_nx;
                    shreg <= shreg_nx;
                    cnt   <= cnt - CNT_W'(1);
                    dirty <= dirty | set_pend[sel];
                    if (cnt == CNT_W'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    // A port that went hex mid-conversion keeps its freshly loaded nibbles.
                    if (!mode_new[sel]) digits[sel] <= acc;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (|pending);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NPORTS; i++)
            if (addr[7:2] == BASE_WORD + 6'(i)) rd_data[DATA_W-1:0] = value[i];
        if (addr[7:2] == BASE_WORD + 6'(NPORTS)) begin
            rd_data[16 +: NPORTS] = pending;
            rd_data[NPORTS-1:0]   = mode;
        end
    end

    always_comb begin
        logic [3:0] nib;
        logic       blank;
`ifdef IO_OUT_LEADZ_BLANK_EN
        logic       lead;
`endif
        seg_out = '0;
        nib     = '0;
        blank   = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
`ifdef IO_OUT_LEADZ_BLANK_EN
            lead = 1'b1;
`endif
            for (int d = DIGITS - 1; d >= 0; d--) begin
                nib   = digits[p][d*4 +: 4];
                blank = 1'b0;
`ifdef IO_OUT_LEADZ_BLANK_EN
                blank = lead && (d != 0) && !mode[p] && (nib == 4'd0);
                lead  = blank;
`endif
                seg_out[(p*DIGITS+d)*7 +: 7] = blank ? 7'b1111111 : seg7(nib);
            end
        end
    end

endmodule

// File: tb/tb_io_output_disp.sv
// Self-checking bench for io_output_disp: directed scenarios plus randomized writes
// against a value/mode model that derives display contents arithmetically.
module tb_io_output_disp;

    localparam int         NPORTS = 3;
    localparam int         DATA_W = 8;
    localparam int         DIGITS = 2;
    localparam logic [5:0] BASE   = 6'h20;
    localparam int         SW     = DIGITS * 7;
    localparam int         CONV   = DATA_W + 2;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic                       io_clk = 1'b0;
    logic                       clrn   = 1'b1;
    logic [31:0]                addr   = '0;
    logic [31:0]                datain = '0;
    logic                       write_io_enable = 1'b0;
    logic [NPORTS*DIGITS*7-1:0] seg_out;
    logic                       busy;
    logic [31:0]                rd_data;

    int n_pass  = 0;
    int n_total = 0;

    int unsigned       mv [NPORTS];
    logic [NPORTS-1:0] mm;

    io_output_disp #(
        .NPORTS(NPORTS), .DATA_W(DATA_W), .DIGITS(DIGITS), .BASE_WORD(BASE)
    ) dut (
        .io_clk(io_clk), .clrn(clrn), .addr(addr), .datain(datain),
        .write_io_enable(write_io_enable), .seg_out(seg_out), .busy(busy), .rd_data(rd_data)
    );

    always #5 io_clk = ~io_clk;

    function automatic logic [31:0] paddr(input int i);
        return 32'((int'(BASE) + i) * 4);
    endfunction

    function automatic logic [SW-1:0] exp_port(input int unsigned v, input logic hex);
        longint unsigned m, p10;
        logic [6:0] s;
        exp_port = '0;
        if (hex) begin
            for (int d = 0; d < DIGITS; d++)
                exp_port[d*7 +: 7] = SEG[int'((v >> (4 * d)) & 15)];
        end else begin
            p10 = 1;
            for (int d = 0; d < DIGITS; d++) p10 = p10 * 10;
            m   = longint'(v) % p10;
            p10 = 1;
            for (int d = 0; d < DIGITS; d++) begin
                s = SEG[int'((m / p10) % 10)];
`ifdef IO_OUT_LEADZ_BLANK_EN
                if (d > 0 && (m / p10) == 0) s = 7'b1111111;
`endif
                exp_port[d*7 +: 7] = s;
                p10 = p10 * 10;
            end
        end
    endfunction

    function automatic logic [NPORTS*DIGITS*7-1:0] exp_all();
        exp_all = '0;
        for (int p = 0; p < NPORTS; p++) exp_all[p*SW +: SW] = exp_port(mv[p], mm[p]);
    endfunction

    function automatic logic [31:0] exp_ctrl(input logic [NPORTS-1:0] pend, input logic [NPORTS-1:0] md);
        return (32'(pend) << 16) | 32'(md);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge io_clk);
        addr = a; datain = d; write_io_enable = 1'b1;
        @(posedge io_clk);
        #1;
        write_io_enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge io_clk);
            #1;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s_timeout: busy=%b required 0", tag, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 clrn = 1'b0;
        #2;
        for (int p = 0; p < NPORTS; p++) begin mv[p] = 0; end
        mm = '0;
        n_total++;
        if (seg_out !== exp_all()) $display("FAIL reset_seg: got %h required %h", seg_out, exp_all());
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else n_pass++;
        addr = paddr(NPORTS);
        #1;
        n_total++;
        if (rd_data !== 32'd0) $display("FAIL reset_ctrl: got %h required 0", rd_data);
        else n_pass++;
        @(negedge io_clk);
        clrn = 1'b1;
    endtask

    task automatic test_decimal_latency();
        logic [SW-1:0] old_seg;
        old_seg = exp_port(mv[0], mm[0]);
        wr(paddr(0), 32'd57);
        mv[0] = 57;
        for (int k = 0; k <= CONV; k++) begin
            if (k > 0) begin @(posedge io_clk); #1; end
            n_total++;
            if (busy !== (k < CONV)) $display("FAIL latency_busy_k%0d: got %b required %b", k, busy, k < CONV);
            else n_pass++;
            if (k == CONV - 1) begin
                n_total++;
                if (seg_out[0 +: SW] !== old_seg) $display("FAIL latency_early: got %h required %h", seg_out[0 +: SW], old_seg);
                else n_pass++;
            end
        end
        n_total++;
        if (seg_out[0 +: SW] !== {7'b0010010, 7'b1111000}) $display("FAIL latency_57: got %h required %h", seg_out[0 +: SW], {7'b0010010, 7'b1111000});
        else n_pass++;
    endtask

    task automatic test_hex();
        wr(paddr(NPORTS), 32'd1);
        mm = 3'b001;
        n_total++;
        if (seg_out[0 +: SW] !== exp_port(mv[0], 1'b1)) $display("FAIL hex_switch: got %h required %h", seg_out[0 +: SW], exp_port(mv[0], 1'b1));
        else n_pass++;
        wr(paddr(0), 32'h3C);
        mv[0] = 32'h3C;
        n_total++;
        if (seg_out[0 +: SW] !== {7'b0110000, 7'b1000110}) $display("FAIL hex_3C: got %h required %h", seg_out[0 +: SW], {7'b0110000, 7'b1000110});
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL hex_busy_k%0d: got %b required 0", k, busy);
            else n_pass++;
            @(posedge io_clk); #1;
        end
        addr = paddr(NPORTS);
        #1;
        n_total++;
        if (rd_data !== exp_ctrl('0, mm)) $display("FAIL hex_ctrl_rd: got %h required %h", rd_data, exp_ctrl('0, mm));
        else n_pass++;
        wr(paddr(NPORTS), 32'd0);
        mm = '0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL hex_to_dec_busy: got %b required 1", busy);
        else n_pass++;
        wait_idle("hex_to_dec");
        n_total++;
        if (seg_out[0 +: SW] !== exp_port(60, 1'b0)) $display("FAIL hex_to_dec_60: got %h required %h", seg_out[0 +: SW], exp_port(60, 1'b0));
        else n_pass++;
    endtask

    task automatic test_modulo();
        wr(paddr(1), 32'd200);
        mv[1] = 200;
        wait_idle("modulo");
        n_total++;
        if (seg_out[SW +: SW] !== exp_port(200, 1'b0)) $display("FAIL modulo_seg: got %h required %h", seg_out[SW +: SW], exp_port(200, 1'b0));
        else n_pass++;
        addr = paddr(1);
        #1;
        n_total++;
        if (rd_data !== 32'd200) $display("FAIL modulo_rd: got %0d required 200", rd_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int unsigned a, b, c, d;
        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
        c = $urandom_range(0, 255); d = $urandom_range(0, 255);
        wr(paddr(2), a);
        @(posedge io_clk); #1;
        wr(paddr(2), b);
        wr(paddr(0), c);
        wr(paddr(1), d);
        addr = paddr(NPORTS);
        for (int k = 5; k <= 4 * CONV; k++) begin
            @(posedge io_clk); #1;
            if (k == CONV) begin
                n_total++;
                if (seg_out[2*SW +: SW] !== exp_port(a, 1'b0)) $display("FAIL b2b_stale2: got %h required %h", seg_out[2*SW +: SW], exp_port(a, 1'b0));
                else n_pass++;
                n_total++;
                if (rd_data !== exp_ctrl(3'b111, '0)) $display("FAIL b2b_pend111: got %h required %h", rd_data, exp_ctrl(3'b111, '0));
                else n_pass++;
            end
            if (k == 2 * CONV) begin
                n_total++;
                if (seg_out[0 +: SW] !== exp_port(c, 1'b0)) $display("FAIL b2b_port0: got %h required %h", seg_out[0 +: SW], exp_port(c, 1'b0));
                else n_pass++;
                n_total++;
                if (rd_data !== exp_ctrl(3'b110, '0)) $display("FAIL b2b_pend110: got %h required %h", rd_data, exp_ctrl(3'b110, '0));
                else n_pass++;
            end
            if (k == 3 * CONV) begin
                n_total++;
                if (seg_out[SW +: SW] !== exp_port(d, 1'b0)) $display("FAIL b2b_port1: got %h required %h", seg_out[SW +: SW], exp_port(d, 1'b0));
                else n_pass++;
                n_total++;
                if (rd_data !== exp_ctrl(3'b100, '0)) $display("FAIL b2b_pend100: got %h required %h", rd_data, exp_ctrl(3'b100, '0));
                else n_pass++;
            end
            if (k == 4 * CONV - 1) begin
                n_total++;
                if (seg_out[2*SW +: SW] !== exp_port(a, 1'b0)) $display("FAIL b2b_port2_hold: got %h required %h", seg_out[2*SW +: SW], exp_port(a, 1'b0));
                else n_pass++;
            end
        end
        n_total++;
        if (seg_out[2*SW +: SW] !== exp_port(b, 1'b0)) $display("FAIL b2b_port2: got %h required %h", seg_out[2*SW +: SW], exp_port(b, 1'b0));
        else n_pass++;
        n_total++;
        if (rd_data !== exp_ctrl(3'b000, '0) || busy !== 1'b0) $display("FAIL b2b_done: rd=%h busy=%b required %h and 0", rd_data, busy, exp_ctrl(3'b000, '0));
        else n_pass++;
        mv[0] = c; mv[1] = d; mv[2] = b;
    endtask

    task automatic test_rewrite();
        logic [SW-1:0] old_seg, want;
        old_seg = exp_port(mv[0], 1'b0);
        wr(paddr(0), 32'd12);
        repeat (3) @(posedge io_clk);
        wr(paddr(0), 32'd34);
        for (int k = 5; k <= 2 * CONV + 2; k++) begin
            @(posedge io_clk); #1;
            want = (k < CONV) ? old_seg : (k < 2 * CONV) ? exp_port(12, 1'b0) : exp_port(34, 1'b0);
            n_total++;
            if (seg_out[0 +: SW] !== want) $display("FAIL rewrite_k%0d: got %h required %h", k, seg_out[0 +: SW], want);
            else n_pass++;
        end
        mv[0] = 34;
    endtask

    task automatic test_random();
        int p;
        int unsigned v;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                v = $urandom_range(0, (1 << NPORTS) - 1);
                wr(paddr(NPORTS), v);
                mm = v[NPORTS-1:0];
                p = NPORTS;
            end else begin
                p = $urandom_range(0, NPORTS - 1);
                v = $urandom_range(0, (1 << DATA_W) - 1);
                wr(paddr(p), v);
                mv[p] = v;
            end
            wait_idle("random");
            n_total++;
            if (seg_out !== exp_all()) $display("FAIL random_seg_it%0d: got %h required %h", it, seg_out, exp_all());
            else n_pass++;
            addr = paddr(p);
            #1;
            n_total++;
            if (p == NPORTS) begin
                if (rd_data !== exp_ctrl('0, mm)) $display("FAIL random_rd_ctrl_it%0d: got %h required %h", it, rd_data, exp_ctrl('0, mm));
                else n_pass++;
            end else begin
                if (rd_data !== 32'(mv[p])) $display("FAIL random_rd_it%0d: got %h required %h", it, rd_data, mv[p]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        wr(paddr(1), 32'd99);
        repeat (3) @(posedge io_clk);
        #3 clrn = 1'b0;
        #1;
        for (int p = 0; p < NPORTS; p++) mv[p] = 0;
        mm = '0;
        addr = paddr(NPORTS);
        #1;
        n_total++;
        if (seg_out !== exp_all()) $display("FAIL midreset_seg: got %h required %h", seg_out, exp_all());
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || rd_data !== 32'd0) $display("FAIL midreset_state: busy=%b ctrl=%h required 0 and 0", busy, rd_data);
        else n_pass++;
        @(negedge io_clk);
        clrn = 1'b1;
        repeat (2) @(posedge io_clk);
        #1;
        n_total++;
        if (seg_out !== exp_all() || busy !== 1'b0) $display("FAIL midreset_no_commit: seg=%h busy=%b required %h and 0", seg_out, busy, exp_all());
        else n_pass++;
        wr(paddr(0), 32'd7);
        mv[0] = 7;
        wait_idle("leadz");
        n_total++;
`ifdef IO_OUT_LEADZ_BLANK_EN
        if (seg_out[0 +: SW] !== {7'b1111111, 7'b1111000}) $display("FAIL leadz_7: got %h required %h", seg_out[0 +: SW], {7'b1111111, 7'b1111000});
`else
        if (seg_out[0 +: SW] !== {7'b1000000, 7'b1111000}) $display("FAIL leadz_7: got %h required %h", seg_out[0 +: SW], {7'b1000000, 7'b1111000});
`endif
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decimal_latency();
        test_hex();
        test_modulo();
        test_back_to_back();
        test_rewrite();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_output_disp.md
Name: io_output_disp

Overview:
- Parametrised memory-mapped output port bank driving seven-segment displays.
- NPORTS write-only data ports, each shown on DIGITS seven-segment digits.
- Each port selectable as decimal or hex display mode.
- Decimal conversion uses one shared iterative shift-add-3 (double-dabble) engine with a per-port pending queue, not per-port dividers.
- Sits on the CPU store path beside data memory, decoded on addr[7:2].

Parameters:
- NPORTS, 3: number of data ports, 1..8.
- DATA_W, 8: bits of datain captured per port, 4..32.
- DIGITS, 2: display digits per port, 1..8.
- BASE_WORD, 6'h20: word address (addr[7:2]) of port 0. Port i sits at BASE_WORD+i; the control register sits at BASE_WORD+NPORTS.

Ports:
- io_clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- addr  in  32  byte address; only addr[7:2] is decoded
- datain  in  32  store data
- write_io_enable  in  1  store strobe, sampled on posedge io_clk
- seg_out  out  NPORTS*DIGITS*7  active-low segments {g,f,e,d,c,b,a}; digit d of port p at bits [(p*DIGITS+d)*7 +: 7]; d=0 is least significant
- busy  out  1  conversion engine not IDLE or any pending bit set
- rd_data  out  32  combinational readback: port i -> stored value, zero-extended; control -> {pending[NPORTS-1:0] at [23:16], mode[NPORTS-1:0] at [7:0]}; else 0

Behaviour:
- Reset, asynchronous on clrn low:
  - port values, digit registers, pending and mode cleared to 0 (all decimal).
  - FSM forced to IDLE.
  - seg_out shows "0" on every digit (7'b1000000); busy = 0.
- Port write: write_io_enable=1 and addr[7:2] = BASE_WORD+i.
  - value[i] <= datain[DATA_W-1:0] at that edge.
  - Decimal mode: pending[i] <= 1.
  - Hex mode: digit[i][d] <= value nibble d at the same edge; nibbles beyond DATA_W read 0; no pending.
- Control write: mode <= datain[NPORTS-1:0].
  - Ports switching to hex reload nibbles at that edge.
  - Ports switching to decimal set pending.
- Writes to any other address are ignored.
- FSM:
  - IDLE: if any pending, select lowest pending index, load shift reg <= value, BCD acc <= 0, cnt <= DATA_W; -> SHIFT.
  - SHIFT: each cycle, add 3 to each BCD nibble >= 5, then shift {acc, shreg} left 1; cnt--. When cnt reaches 0 -> COMMIT.
  - COMMIT: digit[sel] <= acc; clear pending[sel]; -> IDLE.
- Latency: write at edge T gives display update at edge T+DATA_W+2 (10 cycles for DATA_W=8) when the engine is idle.
- Each queued port adds DATA_W+2 cycles.
- Accumulator is DIGITS*4 bits. Carries out of the top digit are discarded, so the display shows value mod 10^DIGITS.
- Rewrite of port sel during SHIFT: the new value is stored and pending stays set through COMMIT, so the port reconverts. The stale result is still committed once, then immediately superseded.
- Mode change of sel to hex during SHIFT/COMMIT: COMMIT result is discarded; the hex nibbles stand.
- Same-edge control write and port write: port write applied first, then mode evaluation on the new value.
- Reset mid-conversion aborts the conversion immediately; no partial digits are committed.

Optional Feature:
- IO_OUT_LEADZ_BLANK_EN defined:
  - In decimal mode, leading zero digits above digit 0 drive 7'b1111111 (blank); digit 0 always shows.
  - Hex mode is unaffected.
  - Blanking is combinational from the digit registers.
- Undefined: all digits always show their value, leading zeros as "0".

Test Plan:
- Reset, then write addr 0x80 datain 57 -> busy=1 for 10 cycles; then port0 digit1=7'b0010010 ("5"), digit0=7'b1111000 ("7"); busy=0.
- Write control 0x8C datain 1, then 0x80 datain 8'h3C -> same edge shows digit1 "3" (7'b0110000), digit0 "C" (7'b1000110); busy stays 0.
- Decimal write 200 to port1 (0x84), DIGITS=2 -> port1 shows "00"; rd_data at 0x84 returns 200.
- Back-to-back writes to ports 2, 0, 1 on consecutive cycles -> commits in order 0, 1, 2 at 10-cycle spacing; pending readback at 0x8C bits[23:16] decrements 3'b111 -> 3'b110 -> 3'b100 -> 0.
- Write 12 to port0, then 34 four cycles later -> "12" committed, then "34" at 10 cycles after the first commit; never any other value.
- Drop clrn mid-SHIFT -> seg_out all "0", busy=0, pending=0 asynchronously. With IO_OUT_LEADZ_BLANK_EN, value 7 shows digit1 7'b1111111.
